// File: rtl/cl_cfg_arb_pkg.sv
// rtl/cl_cfg_arb_pkg.sv - shared types and constants for the cfg bus arbiter
package cl_cfg_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_t;

  // Read data returned to a requester whose access timed out
  localparam logic [31:0] CFG_DEADBEEF = 32'hdead_beef;

  // Requester index width; covers up to 8 requesters
  localparam int IDX_W = 3;

  // Saturating 16-bit increment for status counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cl_cfg_rr_pick.sv
// rtl/cl_cfg_rr_pick.sv - combinational round-robin picker over full slots
module cl_cfg_rr_pick
  import cl_cfg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] full,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any
);

  // Scan from farthest to nearest after ptr so the nearest full slot wins
  always_comb begin
    logic [NUM_REQ-1:0] rot;
    int                 j;
    grant = '0;
    any   = 1'b0;
    rot   = '0;
    j     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j   = (int'(ptr) + k) % NUM_REQ;
      rot = full >> j;
      if (rot[0]) begin
        grant = IDX_W'(j);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cl_cfg_bus_arb.sv
// rtl/cl_cfg_bus_arb.sv - round-robin arbiter sharing one cfg bus among requesters
module cl_cfg_bus_arb
  import cl_cfg_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    sync_rst_n,
  input  logic                    sh_cl_flr_assert_q,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]      req_wr,
  input  logic [NUM_REQ-1:0]      req_rd,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [NUM_REQ*32-1:0]   req_rdata,
  output logic [31:0]             cfg_addr,
  output logic [31:0]             cfg_wdata,
  output logic                    cfg_wr,
  output logic                    cfg_rd,
  input  logic                    cfg_ack,
  input  logic [31:0]             cfg_rdata,
  output logic [15:0]             timeout_cnt,
  output logic [2:0]              last_timeout_id
);

  localparam int            TW          = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYC);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] full_q, wr_q;
  logic [31:0]        addr_q  [NUM_REQ];
  logic [31:0]        wdata_q [NUM_REQ];
  logic [IDX_W-1:0]   ptr_q, grant_q, pick_idx;
  logic               pick_any;
  logic [TW-1:0]      timer_q;
  logic               issue_go, finish, timed_out;
  logic               sel_wr;
  logic [31:0]        sel_addr, sel_wdata;

  cl_cfg_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .full  (full_q),
    .ptr   (ptr_q),
    .grant (pick_idx),
    .any   (pick_any)
  );

  // State register
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) state_q <= ARB_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic; FLR forces IDLE from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (pick_any) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = cfg_ack ? ARB_DONE : ARB_WAIT;
      ARB_WAIT:  if (cfg_ack || timed_out) state_d = ARB_DONE;
      ARB_DONE:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
    if (sh_cl_flr_assert_q) state_d = ARB_IDLE;
  end

  // Control strobes and winning-slot mux; ack beats timeout in the same cycle
  always_comb begin
    issue_go  = 1'b0;
    finish    = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    timed_out = (TIMEOUT_CYC != 0) && (state_q == ARB_WAIT) && !cfg_ack &&
                (timer_q == TIMEOUT_VAL);
    if (!sh_cl_flr_assert_q) begin
      issue_go = (state_q == ARB_IDLE) && pick_any;
      finish   = ((state_q == ARB_ISSUE) && cfg_ack) ||
                 ((state_q == ARB_WAIT) && (cfg_ack || timed_out));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_wr    = wr_q[i];
        sel_addr  = addr_q[i];
        sel_wdata = wdata_q[i];
      end
    end
  end

  // Pending slots: capture into an empty slot, free on completion, flush on FLR
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      full_q <= '0;
      wr_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (sh_cl_flr_assert_q) begin
          full_q[i] <= 1'b0;
        end else if (!full_q[i] && (req_wr[i] || req_rd[i])) begin
          full_q[i]  <= 1'b1;
          wr_q[i]    <= req_wr[i];
          addr_q[i]  <= req_addr[32*i +: 32];
          wdata_q[i] <= req_wdata[32*i +: 32];
        end else if (finish && (grant_q == IDX_W'(i))) begin
          full_q[i] <= 1'b0;
        end
      end
    end
  end

  // Downstream issue, timer, completion back to the winner, status counters
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      cfg_wr          <= 1'b0;
      cfg_rd          <= 1'b0;
      cfg_addr        <= '0;
      cfg_wdata       <= '0;
      req_ack         <= '0;
      req_rdata       <= '0;
      timeout_cnt     <= '0;
      last_timeout_id <= '0;
      grant_q         <= '0;
      ptr_q           <= IDX_W'(NUM_REQ - 1);
      timer_q         <= '0;
    end else begin
      cfg_wr <= issue_go && sel_wr;
      cfg_rd <= issue_go && !sel_wr;
      if (issue_go) begin
        cfg_addr  <= sel_addr;
        cfg_wdata <= sel_wdata;
        grant_q   <= pick_idx;
      end
      if (issue_go)
        timer_q <= '0;
      else if ((state_q == ARB_ISSUE) || (state_q == ARB_WAIT))
        timer_q <= timer_q + 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ack[i] <= finish && (grant_q == IDX_W'(i));
        if (finish && (grant_q == IDX_W'(i)))
          req_rdata[32*i +: 32] <= cfg_ack ? cfg_rdata : CFG_DEADBEEF;
      end
      if (finish && !cfg_ack) begin
        timeout_cnt     <= sat_inc16(timeout_cnt);
        last_timeout_id <= grant_q;
      end
      if ((state_q == ARB_DONE) && !sh_cl_flr_assert_q)
        ptr_q <= grant_q;
    end
  end

endmodule

// File: tb/tb_cl_cfg_bus_arb.sv
// tb/tb_cl_cfg_bus_arb.sv - directed scoreboard bench for cl_cfg_bus_arb
module tb_cl_cfg_bus_arb;

  localparam int NR = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            sync_rst_n;
  logic            flr;
  logic [NR*32-1:0] req_addr, req_wdata;
  logic [NR-1:0]   req_wr, req_rd, req_ack;
  logic [NR*32-1:0] req_rdata;
  logic [31:0]     cfg_addr, cfg_wdata, cfg_rdata;
  logic            cfg_wr, cfg_rd, cfg_ack;
  logic [15:0]     timeout_cnt;
  logic [2:0]      last_timeout_id;

  always #5 clk = ~clk;

  cl_cfg_bus_arb #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk                (clk),
    .sync_rst_n         (sync_rst_n),
    .sh_cl_flr_assert_q (flr),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .req_wr             (req_wr),
    .req_rd             (req_rd),
    .req_ack            (req_ack),
    .req_rdata          (req_rdata),
    .cfg_addr           (cfg_addr),
    .cfg_wdata          (cfg_wdata),
    .cfg_wr             (cfg_wr),
    .cfg_rd             (cfg_rd),
    .cfg_ack            (cfg_ack),
    .cfg_rdata          (cfg_rdata),
    .timeout_cnt        (timeout_cnt),
    .last_timeout_id    (last_timeout_id)
  );

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; } cfg_exp_t;
  typedef struct { int id; logic [31:0] rdata; } ack_exp_t;

  cfg_exp_t cfg_q[$];
  ack_exp_t ack_q[$];
  cfg_exp_t mon_c;
  ack_exp_t mon_a;

  int n_asrt = 0;
  int n_fail = 0;

  int          slave_mode = 2;
  logic [31:0] slave_xor  = '0;
  logic        inject_ack = 1'b0;
  int          ack_cnt    = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int id);
    return 32'hd000_0000 | 32'(id);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int id, input logic [31:0] a);
    req_addr[32*id +: 32] = a;
  endtask

  task automatic pulse(input logic [NR-1:0] wm, input logic [NR-1:0] rm);
    req_wr = wm;
    req_rd = rm;
    tick();
    req_wr = '0;
    req_rd = '0;
  endtask

  task automatic expect_cfg(input int id, input logic wr, input logic [31:0] a);
    cfg_exp_t e;
    e.wr = wr; e.addr = a; e.wdata = wd(id);
    cfg_q.push_back(e);
  endtask

  task automatic expect_ack(input int id, input logic [31:0] rd);
    ack_exp_t e;
    e.id = id; e.rdata = rd;
    ack_q.push_back(e);
  endtask

  // Downstream slave model: immediate ack, ack two cycles later, or silent
  always @(negedge clk) begin
    cfg_ack   = 1'b0;
    cfg_rdata = 32'h0bad_0bad;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        cfg_ack   = 1'b1;
        cfg_rdata = slave_xor ^ cfg_addr;
      end
    end
    if (cfg_wr || cfg_rd) begin
      if (slave_mode == 0) begin
        cfg_ack   = 1'b1;
        cfg_rdata = slave_xor ^ cfg_addr;
      end else if (slave_mode == 1) begin
        ack_cnt = 2;
      end
    end
    if (inject_ack) begin
      cfg_ack    = 1'b1;
      cfg_rdata  = 32'h5555_aaaa;
      inject_ack = 1'b0;
    end
  end

  // Scoreboard monitor: every cfg pulse and req_ack must match the next expectation
  always @(negedge clk) begin
    if (sync_rst_n) begin
      if (cfg_wr || cfg_rd) begin
        check32("cfg_access_expected", 32'(cfg_q.size() != 0), 32'd1);
        if (cfg_q.size() != 0) begin
          mon_c = cfg_q.pop_front();
          check32("sb_cfg_wr", 32'(cfg_wr), 32'(mon_c.wr));
          check32("sb_cfg_rd", 32'(cfg_rd), 32'(!mon_c.wr));
          check32("sb_cfg_addr", cfg_addr, mon_c.addr);
          check32("sb_cfg_wdata", cfg_wdata, mon_c.wdata);
        end
      end
      if (req_ack != '0) begin
        check32("req_ack_expected", 32'(ack_q.size() != 0), 32'd1);
        if (ack_q.size() != 0) begin
          mon_a = ack_q.pop_front();
          check32("sb_req_ack", 32'(req_ack), 32'(1 << mon_a.id));
          check32("sb_req_rdata", req_rdata[32*mon_a.id +: 32], mon_a.rdata);
        end
      end
    end
  end

  initial begin
    sync_rst_n = 1'b0;
    flr        = 1'b0;
    req_wr     = '0;
    req_rd     = '0;
    req_addr   = '0;
    for (int i = 0; i < NR; i++) req_wdata[32*i +: 32] = wd(i);
    repeat (3) @(posedge clk);
    #1 sync_rst_n = 1'b1;

    // reset state
    check32("rst_cfg_wr", 32'(cfg_wr), 32'd0);
    check32("rst_cfg_rd", 32'(cfg_rd), 32'd0);
    check32("rst_cfg_addr", cfg_addr, 32'd0);
    check32("rst_req_ack", 32'(req_ack), 32'd0);
    check32("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    check32("rst_last_id", 32'(last_timeout_id), 32'd0);
    for (int i = 0; i < NR; i++) check32("rst_req_rdata", req_rdata[32*i +: 32], 32'd0);

    // all four write together, ack in ISSUE: served 0,1,2,3 three cycles apart
    slave_mode = 0;
    slave_xor  = 32'h5a5a_0000;
    for (int i = 0; i < NR; i++) begin
      set_addr(i, 32'h200 + 32'(4 * i));
      expect_cfg(i, 1'b1, 32'h200 + 32'(4 * i));
      expect_ack(i, slave_xor ^ (32'h200 + 32'(4 * i)));
    end
    pulse(4'hf, 4'h0);
    tick();
    for (int i = 0; i < NR; i++) begin
      check32("t2_cfg_wr_slot", 32'(cfg_wr), 32'd1);
      check32("t2_cfg_addr_order", cfg_addr, 32'h200 + 32'(4 * i));
      repeat (3) tick();
    end
    repeat (2) tick();
    // pointer now at 3: requesters 1 and 3 go 1 then 3
    set_addr(1, 32'h304);
    set_addr(3, 32'h30c);
    expect_cfg(1, 1'b1, 32'h304); expect_ack(1, slave_xor ^ 32'h304);
    expect_cfg(3, 1'b1, 32'h30c); expect_ack(3, slave_xor ^ 32'h30c);
    pulse(4'b1010, 4'h0);
    tick();
    check32("t2_pair_first", cfg_addr, 32'h304);
    repeat (3) tick();
    check32("t2_pair_second", cfg_addr, 32'h30c);
    repeat (4) tick();

    // single read, slave acks two cycles after cfg_rd
    slave_mode = 1;
    slave_xor  = 32'h1234_5678 ^ 32'h0000_0104;
    set_addr(0, 32'h104);
    expect_cfg(0, 1'b0, 32'h104);
    expect_ack(0, 32'h1234_5678);
    pulse(4'h0, 4'b0001);
    tick();
    check32("t1_cfg_rd_at_T2", 32'(cfg_rd), 32'd1);
    check32("t1_cfg_wr_low", 32'(cfg_wr), 32'd0);
    tick();
    check32("t1_no_ack_early1", 32'(req_ack), 32'd0);
    tick();
    check32("t1_no_ack_early2", 32'(req_ack), 32'd0);
    tick();
    check32("t1_req_ack", 32'(req_ack), 32'b0001);
    check32("t1_req_rdata", req_rdata[31:0], 32'h1234_5678);
    repeat (3) tick();

    // silent slave: timeout completion at ISSUE+17, late ack ignored
    slave_mode = 2;
    set_addr(2, 32'h840);
    expect_cfg(2, 1'b0, 32'h840);
    expect_ack(2, 32'hdead_beef);
    pulse(4'h0, 4'b0100);
    tick();
    check32("t3_cfg_rd", 32'(cfg_rd), 32'd1);
    repeat (16) tick();
    check32("t3_no_ack_before_to", 32'(req_ack), 32'd0);
    tick();
    check32("t3_to_ack", 32'(req_ack), 32'b0100);
    check32("t3_to_rdata", req_rdata[64 +: 32], 32'hdead_beef);
    check32("t3_to_cnt", 32'(timeout_cnt), 32'd1);
    check32("t3_to_id", 32'(last_timeout_id), 32'd2);
    repeat (4) tick();
    inject_ack = 1'b1;
    repeat (4) tick();
    check32("t3_late_ack_rdata", req_rdata[64 +: 32], 32'hdead_beef);
    check32("t3_late_ack_cnt", 32'(timeout_cnt), 32'd1);

    // wr+rd together -> write; extra pulse while pending dropped
    slave_mode = 1;
    slave_xor  = 32'h0f0f_0000;
    set_addr(2, 32'ha00);
    expect_cfg(2, 1'b1, 32'ha00);
    expect_ack(2, 32'h0f0f_0000 ^ 32'ha00);
    req_wr = 4'b0100;
    req_rd = 4'b0100;
    tick();
    set_addr(2, 32'hbbb0);
    req_wr = '0;
    req_rd = 4'b0100;
    tick();
    req_rd = '0;
    check32("t4_cfg_wr", 32'(cfg_wr), 32'd1);
    check32("t4_cfg_rd", 32'(cfg_rd), 32'd0);
    check32("t4_cfg_addr", cfg_addr, 32'ha00);
    repeat (3) tick();
    check32("t4_req_ack", 32'(req_ack), 32'b0100);
    repeat (8) tick();

    // FLR in WAIT with 1 and 2 pending: no acks, slots flushed
    slave_mode = 2;
    set_addr(1, 32'h110);
    set_addr(2, 32'h220);
    expect_cfg(1, 1'b0, 32'h110);
    pulse(4'h0, 4'b0110);
    tick();
    check32("t5_cfg_rd_req1", cfg_addr, 32'h110);
    tick();
    flr    = 1'b1;
    req_rd = 4'b1000;
    tick();
    flr    = 1'b0;
    req_rd = '0;
    for (int i = 0; i < 25; i++) begin
      check32("t5_quiet_after_flr", {26'd0, cfg_wr, cfg_rd, req_ack}, 32'd0);
      tick();
    end
    check32("t5_to_cnt_kept", 32'(timeout_cnt), 32'd1);
    check32("t5_to_id_kept", 32'(last_timeout_id), 32'd2);
    slave_mode = 0;
    slave_xor  = 32'h7777_0000;
    set_addr(0, 32'h010);
    expect_cfg(0, 1'b0, 32'h010);
    expect_ack(0, 32'h7777_0010);
    pulse(4'h0, 4'b0001);
    tick();
    check32("t5_post_flr_cfg_rd", 32'(cfg_rd), 32'd1);
    tick();
    check32("t5_post_flr_ack", 32'(req_ack), 32'b0001);
    repeat (3) tick();

    // async reset mid-WAIT
    slave_mode = 2;
    set_addr(3, 32'h3c0);
    expect_cfg(3, 1'b0, 32'h3c0);
    pulse(4'h0, 4'b1000);
    tick();
    tick();
    #2 sync_rst_n = 1'b0;
    #1;
    check32("t6_rst_cfg_addr", cfg_addr, 32'd0);
    check32("t6_rst_cfg_rd", 32'(cfg_rd), 32'd0);
    check32("t6_rst_to_cnt", 32'(timeout_cnt), 32'd0);
    check32("t6_rst_to_id", 32'(last_timeout_id), 32'd0);
    check32("t6_rst_rdata0", req_rdata[31:0], 32'd0);
    check32("t6_rst_rdata2", req_rdata[64 +: 32], 32'd0);
    tick();
    sync_rst_n = 1'b1;
    slave_mode = 0;
    slave_xor  = 32'h0101_0000;
    set_addr(0, 32'h400);
    set_addr(1, 32'h404);
    expect_cfg(0, 1'b0, 32'h400); expect_ack(0, 32'h0101_0400);
    expect_cfg(1, 1'b0, 32'h404); expect_ack(1, 32'h0101_0404);
    pulse(4'h0, 4'b0011);
    tick();
    check32("t6_first_grant_req0", cfg_addr, 32'h400);
    repeat (3) tick();
    check32("t6_second_grant_req1", cfg_addr, 32'h404);
    repeat (5) tick();

    check32("sb_cfg_q_drained", 32'(cfg_q.size()), 32'd0);
    check32("sb_ack_q_drained", 32'(ack_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
